// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - mem_ctrl codes, LSU state type and size/sign decode helpers
package load_store_unit_pkg;

  localparam logic [3:0] MEM_NONE   = 4'h0;
  localparam logic [3:0] MEM_LOAD1  = 4'h1;
  localparam logic [3:0] MEM_LOAD2  = 4'h2;
  localparam logic [3:0] MEM_LOAD4  = 4'h3;
  localparam logic [3:0] MEM_LOAD1U = 4'h4;
  localparam logic [3:0] MEM_LOAD2U = 4'h5;
  localparam logic [3:0] MEM_STORE1 = 4'h8;
  localparam logic [3:0] MEM_STORE2 = 4'h9;
  localparam logic [3:0] MEM_STORE4 = 4'hA;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  // SZ_NONE doubles as "no bus access": MEM_NONE and every undefined code
  function automatic lsu_size_t mem_size(input logic [3:0] op);
    case (op)
      MEM_LOAD1, MEM_LOAD1U, MEM_STORE1: return SZ_BYTE;
      MEM_LOAD2, MEM_LOAD2U, MEM_STORE2: return SZ_HALF;
      MEM_LOAD4, MEM_STORE4:             return SZ_WORD;
      default:                           return SZ_NONE;
    endcase
  endfunction

  function automatic logic mem_is_store(input logic [3:0] op);
    return (op == MEM_STORE1) || (op == MEM_STORE2) || (op == MEM_STORE4);
  endfunction

  function automatic logic mem_is_signed(input logic [3:0] op);
    return (op == MEM_LOAD1) || (op == MEM_LOAD2);
  endfunction

  function automatic logic mem_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane strobes, store-data replication and load extract/extend
module lsu_align
  import load_store_unit_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{offset, 3'b000} +: 8];
  assign half_sel = rword[{offset[1], 4'b0000} +: 16];

  always_comb begin
    wstrb       = 4'b0000;
    wdata_lanes = 32'h0;
    rdata_ext   = 32'h0;
    case (size)
      SZ_BYTE: begin
        wstrb       = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        wstrb       = 4'b0011 << offset;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        wstrb       = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: begin
        wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store FSM with word-aligned bus transaction and timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic        word_ok;
  logic        req_q;
  logic [CW-1:0] tcnt;
  logic        timed_out;
  lsu_size_t   in_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign in_size   = mem_size(mem_ctrl);
  assign timed_out = (TIMEOUT != 0) && (tcnt == CW'(TIMEOUT - 1));

  lsu_align u_align (
    .size        (mem_size(op_q)),
    .sign_ext    (mem_is_signed(op_q)),
    .offset      (off_q),
    .wdata       (wdata_q),
    .rword       (rword_q),
    .wstrb       (al_wstrb),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  // bus_req drops in the same cycle reset is raised, not one edge later
  assign bus_req   = req_q & ~rst;
  assign bus_wstrb = bus_we ? al_wstrb : 4'b0000;
  assign bus_wdata = bus_we ? al_wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      req_q      <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      rdata      <= 32'h0;
      op_q       <= MEM_NONE;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      rword_q    <= 32'h0;
      word_ok    <= 1'b0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= mem_ctrl;
            off_q     <= addr[1:0];
            wdata_q   <= wdata;
            bus_addr  <= {addr[31:2], 2'b00};
            rdata     <= 32'h0;
            word_ok   <= 1'b0;
            tcnt      <= '0;
            req_ready <= 1'b0;
            if (in_size == SZ_NONE) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (mem_misaligned(in_size, addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              misalign   <= 1'b1;
            end else begin
              state  <= REQ;
              req_q  <= 1'b1;
              bus_we <= mem_is_store(mem_ctrl);
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            req_q <= 1'b0;
            if (bus_we) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= RDWAIT;
              tcnt  <= tcnt + CW'(1);
              if (bus_rvalid) begin
                rword_q <= bus_rdata;
                word_ok <= 1'b1;
              end
            end
          end else if (timed_out) begin
            req_q      <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            bus_err    <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        RDWAIT: begin
          // the captured word is extended one cycle after capture
          if (word_ok) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            rdata      <= al_rdata;
          end else if (bus_rvalid) begin
            rword_q <= bus_rdata;
            word_ok <= 1'b1;
          end else if (timed_out) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            bus_err    <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          misalign   <= 1'b0;
          bus_err    <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
